// File: rtl/mem_access_unit.sv
// Load/store unit between the multicycle datapath and a word-wide memory port.
// Handles sub-word loads with extension, byte-masked stores and optional split of word-crossing accesses.
module mem_access_unit #(
    parameter int unsigned DATA_W           = 32,
    parameter int unsigned ADDR_W           = 32,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_mbe,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned OW = $clog2(NB);

    typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   word0_q, word0_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                gap_q, gap_d;

    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] v,
                                                      input logic [1:0] size,
                                                      input logic uns);
        int unsigned         bits;
        logic [DATA_W-1:0] mask;
        bits = 32'd8 << size;
        if (bits >= DATA_W) begin
            return v;
        end
        mask = (DATA_W'(1) << bits) - DATA_W'(1);
        if (!uns && v[bits-1]) begin
            return v | ~mask;
        end
        return v & mask;
    endfunction

    // Request decode, evaluated on the incoming fields during the handshake cycle.
    logic [OW-1:0] req_off;
    logic [OW:0]   req_n;
    logic [OW:0]   req_n_m1;
    logic          req_misaligned;
    logic          req_err;

    always_comb begin
        req_off        = req_addr[OW-1:0];
        req_n          = (OW+1)'(1) << req_funct3[1:0];
        req_n_m1       = req_n - (OW+1)'(1);
        req_misaligned = |(req_off & req_n_m1[OW-1:0]);
        req_err        = ((DATA_W == 32) && (req_funct3[1:0] == 2'd3))
                       || (req_write && req_funct3[2])
                       || (req_misaligned && !SPLIT_MISALIGNED);
    end

    // Captured-request derived values.
    logic [OW-1:0]         off_q;
    logic [OW:0]           n_q;
    logic                  split;
    logic [ADDR_W-1:0]     word_addr;
    logic [2*NB-1:0]       lane_mask;
    logic [2*DATA_W-1:0]   wide_wdata;
    logic [DATA_W-1:0]     lo_word;
    logic [2*DATA_W-1:0]   wide_rdata;
    logic [DATA_W-1:0]     load_data;
    logic                  strobe;

    always_comb begin
        off_q      = addr_q[OW-1:0];
        n_q        = (OW+1)'(1) << funct3_q[1:0];
        split      = (({1'b0, off_q} + n_q) > (OW+1)'(NB));
        word_addr  = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
        lane_mask  = (((2*NB)'(1) << n_q) - (2*NB)'(1)) << off_q;
        wide_wdata = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};
        // Second transaction: low half comes from the first word latched in ACC0.
        lo_word    = (state_q == StAcc1) ? word0_q : mem_rdata;
        wide_rdata = {mem_rdata, lo_word} >> {off_q, 3'b000};
        load_data  = extend_load(wide_rdata[DATA_W-1:0], funct3_q[1:0], funct3_q[2]);
        strobe     = (state_q == StAcc0) || ((state_q == StAcc1) && !gap_q);
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        word0_d  = word0_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        gap_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_err) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StAcc0;
                    end
                end
            end
            StAcc0: begin
                if (mem_resp) begin
                    word0_d = mem_rdata;
                    if (split) begin
                        gap_d   = 1'b1;
                        state_d = StAcc1;
                    end else begin
                        rdata_d = write_q ? '0 : load_data;
                        err_d   = 1'b0;
                        state_d = StResp;
                    end
                end
            end
            StAcc1: begin
                if (!gap_q && mem_resp) begin
                    rdata_d = write_q ? '0 : load_data;
                    err_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            word0_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            gap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word0_q  <= word0_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            gap_q    <= gap_d;
        end
    end

    // req_ready is gated by rst so it reads 0 while reset is held.
    always_comb begin
        req_ready   = rst && (state_q == StIdle);
        rsp_valid   = (state_q == StResp);
        rsp_rdata   = rdata_q;
        rsp_err     = err_q;
        mem_read    = strobe && !write_q;
        mem_write   = strobe && write_q;
        mem_address = '0;
        mem_wdata   = '0;
        mem_mbe     = '0;
        if (strobe) begin
            if (state_q == StAcc1) begin
                mem_address = word_addr + ADDR_W'(NB);
                mem_mbe     = write_q ? lane_mask[2*NB-1:NB] : '1;
                mem_wdata   = write_q ? wide_wdata[2*DATA_W-1:DATA_W] : '0;
            end else begin
                mem_address = word_addr;
                mem_mbe     = write_q ? lane_mask[NB-1:0] : '1;
                mem_wdata   = write_q ? wide_wdata[DATA_W-1:0] : '0;
            end
        end
    end

endmodule
